// File: rtl/ibuf.sv
// ---------------------------------------------------------------------------
// ibuf -- input buffer for the external oscillator pin.
//
// The raw pad level is passed straight through on O for use as the core
// clock net. In parallel, the pad is sampled in the osc domain to produce a
// conditioned copy for status and diagnostic logic:
//   * a SYNC_STAGES-deep synchroniser,
//   * a glitch filter that accepts a new level only after it has persisted
//     for FILTER_LEN consecutive osc edges,
//   * single-cycle rise/fall pulses on the filtered level,
//   * an activity flag that stays high for TIMEOUT cycles after each
//     filtered edge.
//
// Ports
//   osc     in   sampling clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   I       in   raw pad input
//   O       out  pad input passed through, combinational
//   O_filt  out  synchronised, glitch-filtered level
//   rise    out  one-cycle pulse when O_filt goes 0->1
//   fall    out  one-cycle pulse when O_filt goes 1->0
//   active  out  a filtered edge occurred within the last TIMEOUT cycles
// ---------------------------------------------------------------------------
module ibuf #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT     = 24000
) (
  input  logic osc,
  input  logic rst_n,
  input  logic I,
  output logic O,
  output logic O_filt,
  output logic rise,
  output logic fall,
  output logic active
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [FW-1:0] FCNT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [FW-1:0] FCNT_ONE  = FW'(1);
  localparam logic [TW-1:0] TCNT_LOAD = TW'(TIMEOUT);
  localparam logic [TW-1:0] TCNT_ONE  = TW'(1);

  // Pad pass-through: no register, no gating, independent of reset.
  assign O = I;

  // -------------------------------------------------------------------------
  // Synchroniser chain
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   s;

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge osc or negedge rst_n) begin
          if (!rst_n) sync_reg[gi] <= 1'b0;
          else        sync_reg[gi] <= I;
        end
      end else begin : g_rest
        always_ff @(posedge osc or negedge rst_n) begin
          if (!rst_n) sync_reg[gi] <= 1'b0;
          else        sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign s = sync_reg[SYNC_STAGES-1];

  // -------------------------------------------------------------------------
  // Glitch filter, edge pulses and activity timer
  // -------------------------------------------------------------------------
  logic          filt_reg, filt_next;
  logic [FW-1:0] fcnt_reg, fcnt_next;
  logic          rise_reg, rise_next;
  logic          fall_reg, fall_next;
  logic [TW-1:0] tcnt_reg, tcnt_next;
  logic          accept;

  // The synchronised level has differed from the filtered level for
  // FILTER_LEN consecutive edges, including this one.
  assign accept = (s != filt_reg) && (fcnt_reg == FCNT_LAST);

  always_comb begin
    filt_next = filt_reg;
    fcnt_next = fcnt_reg;
    rise_next = 1'b0;
    fall_next = 1'b0;
    tcnt_next = tcnt_reg;

    if (s == filt_reg) begin
      // Any excursion shorter than FILTER_LEN is forgotten.
      fcnt_next = '0;
    end else if (accept) begin
      filt_next = s;
      fcnt_next = '0;
    end else begin
      fcnt_next = fcnt_reg + FCNT_ONE;
    end

    // Pulses are registered alongside the filtered level so they line up
    // with the cycle in which O_filt shows its new value.
    if (accept) begin
      rise_next = s;
      fall_next = ~s;
    end

    // An accepted edge always reloads the timer, even when it is about to
    // expire, so active never drops between closely spaced edges.
    if (accept) begin
      tcnt_next = TCNT_LOAD;
    end else if (tcnt_reg != '0) begin
      tcnt_next = tcnt_reg - TCNT_ONE;
    end
  end

  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      filt_reg <= 1'b0;
      fcnt_reg <= '0;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
      tcnt_reg <= '0;
    end else begin
      filt_reg <= filt_next;
      fcnt_reg <= fcnt_next;
      rise_reg <= rise_next;
      fall_reg <= fall_next;
      tcnt_reg <= tcnt_next;
    end
  end

  assign O_filt = filt_reg;
  assign rise   = rise_reg;
  assign fall   = fall_reg;
  assign active = (tcnt_reg != '0);

endmodule

// File: tb/tb_ibuf.sv
// ---------------------------------------------------------------------------
// tb_ibuf -- self-checking bench for ibuf.
//
// Two instances share the pad, clock and reset: one with FILTER_LEN=4 and
// one with FILTER_LEN=1, both with TIMEOUT=20. A reference model keeps the
// history of pad samples taken at each osc edge and derives the filtered
// level from the rule "the synchronised level seen on the last FILTER_LEN
// edges all differed from the filtered level", and the activity flag from
// the distance to the most recent filtered edge.
// ---------------------------------------------------------------------------
module tb_ibuf;

  localparam int SYNC = 2;
  localparam int TMO  = 20;
  localparam int FL_A = 4;
  localparam int FL_B = 1;

  logic osc   = 1'b0;
  logic rst_n = 1'b0;
  logic I     = 1'b0;

  logic O_a, O_filt_a, rise_a, fall_a, active_a;
  logic O_b, O_filt_b, rise_b, fall_b, active_b;

  ibuf #(.SYNC_STAGES(SYNC), .FILTER_LEN(FL_A), .TIMEOUT(TMO)) dut_a (
    .osc(osc), .rst_n(rst_n), .I(I),
    .O(O_a), .O_filt(O_filt_a), .rise(rise_a), .fall(fall_a), .active(active_a)
  );

  ibuf #(.SYNC_STAGES(SYNC), .FILTER_LEN(FL_B), .TIMEOUT(TMO)) dut_b (
    .osc(osc), .rst_n(rst_n), .I(I),
    .O(O_b), .O_filt(O_filt_b), .rise(rise_b), .fall(fall_b), .active(active_b)
  );

  initial forever #5 osc = ~osc;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model
  // ------------------------------------------------------------------
  bit ihist[$];
  int n_edge;
  int fl[2]   = '{FL_A, FL_B};
  bit mf[2];
  bit mr[2];
  bit mfl[2];
  int last[2];

  task automatic model_reset();
    ihist.delete();
    n_edge = 0;
    for (int k = 0; k < 2; k++) begin
      mf[k] = 0; mr[k] = 0; mfl[k] = 0; last[k] = -1;
    end
  endtask

  // Synchronised level presented to the filter at edge e: the pad value
  // sampled SYNC edges earlier, zero before that.
  function automatic bit sp(input int e);
    if (e < SYNC) return 1'b0;
    return ihist[e - SYNC];
  endfunction

  task automatic model_edge();
    ihist.push_back(I);
    for (int k = 0; k < 2; k++) begin
      bit ok = 1'b1;
      for (int j = 0; j < fl[k]; j++)
        if (sp(n_edge - j) == mf[k]) ok = 1'b0;
      if (ok) begin
        mf[k]   = ~mf[k];
        mr[k]   = mf[k];
        mfl[k]  = ~mf[k];
        last[k] = n_edge;
      end else begin
        mr[k]  = 1'b0;
        mfl[k] = 1'b0;
      end
    end
    n_edge++;
  endtask

  function automatic bit m_active(input int k);
    return (last[k] >= 0) && ((n_edge - 1 - last[k]) < TMO);
  endfunction

  task automatic check_outs();
    check_eq("a.O_filt", O_filt_a, mf[0]);
    check_eq("a.rise",   rise_a,   mr[0]);
    check_eq("a.fall",   fall_a,   mfl[0]);
    check_eq("a.active", active_a, m_active(0));
    check_eq("b.O_filt", O_filt_b, mf[1]);
    check_eq("b.rise",   rise_b,   mr[1]);
    check_eq("b.fall",   fall_b,   mfl[1]);
    check_eq("b.active", active_b, m_active(1));
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, ".a.O_filt"}, O_filt_a, 0);
    check_eq({tag, ".a.rise"},   rise_a,   0);
    check_eq({tag, ".a.fall"},   fall_a,   0);
    check_eq({tag, ".a.active"}, active_a, 0);
    check_eq({tag, ".b.O_filt"}, O_filt_b, 0);
    check_eq({tag, ".b.rise"},   rise_b,   0);
    check_eq({tag, ".b.fall"},   fall_b,   0);
    check_eq({tag, ".b.active"}, active_b, 0);
  endtask

  // One osc cycle: drive the pad just after a falling edge, advance the
  // model over the coming rising edge, then check at the next falling edge.
  task automatic cycle(input logic v);
    I = v;
    if (rst_n) model_edge();
    #1;
    check_eq("a.O", O_a, I);
    check_eq("b.O", O_b, I);
    @(negedge osc);
    if (rst_n) check_outs();
    else       check_zero("rst");
  endtask

  int lat_a, lat_b, act_a, act_b, rise_cnt, fall_cnt, rise_k, fall_k, gap_cnt;

  initial begin
    model_reset();

    // Held in reset for a few cycles, then released on a falling edge.
    @(negedge osc);
    cycle(1'b0);
    cycle(1'b1);
    cycle(1'b0);
    rst_n = 1'b1;
    model_reset();
    $display("reset released");

    // Quiet pad.
    for (int k = 0; k < 50; k++) cycle(1'b0);
    check_eq("quiet.active", active_a, 0);
    $display("quiet pad: 50 cycles");

    // Clean 0->1 step: latency to the rise pulse and active duration.
    lat_a = 0; lat_b = 0; act_a = 0; act_b = 0;
    for (int k = 1; k <= 40; k++) begin
      cycle(1'b1);
      if (rise_a === 1'b1 && lat_a == 0) lat_a = k;
      if (rise_b === 1'b1 && lat_b == 0) lat_b = k;
      if (active_a === 1'b1) act_a++;
      if (active_b === 1'b1) act_b++;
    end
    check_eq("step.lat_a", lat_a, SYNC + FL_A);
    check_eq("step.lat_b", lat_b, SYNC + FL_B);
    check_eq("step.act_a", act_a, TMO);
    check_eq("step.act_b", act_b, TMO);
    $display("step: latency a=%0d b=%0d, active a=%0d b=%0d cycles", lat_a, lat_b, act_a, act_b);

    for (int k = 0; k < 30; k++) cycle(1'b0);

    // 3-cycle glitch must be rejected by the FILTER_LEN=4 instance.
    rise_cnt = 0; fall_cnt = 0;
    for (int k = 0; k < 23; k++) begin
      cycle(k < 3);
      if (rise_a === 1'b1) rise_cnt++;
      if (fall_a === 1'b1) fall_cnt++;
    end
    check_eq("glitch3.rise", rise_cnt, 0);
    check_eq("glitch3.fall", fall_cnt, 0);
    $display("3-cycle glitch: rise=%0d fall=%0d", rise_cnt, fall_cnt);

    // 4-cycle pulse is accepted: rise then fall four cycles apart.
    rise_k = -1; fall_k = -1;
    for (int k = 0; k < 24; k++) begin
      cycle(k < 4);
      if (rise_a === 1'b1) rise_k = k;
      if (fall_a === 1'b1) fall_k = k;
    end
    check_eq("pulse4.seen", (rise_k >= 0 && fall_k >= 0), 1);
    check_eq("pulse4.gap", fall_k - rise_k, FL_A);
    $display("4-cycle pulse: rise at %0d fall at %0d", rise_k, fall_k);

    for (int k = 0; k < 30; k++) cycle(1'b0);

    // Square wave, period 16: active must never drop once running.
    gap_cnt = 0;
    for (int k = 0; k < 96; k++) begin
      cycle(((k / 8) % 2) == 0);
      if (k >= 16 && active_a !== 1'b1) gap_cnt++;
    end
    check_eq("square.gaps", gap_cnt, 0);
    $display("square wave: inactive cycles after start=%0d", gap_cnt);

    // Random runs of random length.
    begin
      int k = 0;
      while (k < 600) begin
        logic v = 1'($urandom_range(0, 1));
        int   len = $urandom_range(1, 8);
        for (int j = 0; j < len; j++) cycle(v);
        k += len;
      end
    end
    $display("random runs: done");

    // Asynchronous reset while filtered level is high and active.
    for (int k = 0; k < 12; k++) cycle(1'b1);
    check_eq("pre_arst.O_filt", O_filt_a, 1);
    check_eq("pre_arst.active", active_a, 1);
    #2 rst_n = 1'b0;
    #1;
    check_zero("arst");
    check_eq("arst.O", O_a, I);
    I = 1'b0;
    #1 check_eq("arst.O0", O_a, 1'b0);
    model_reset();
    @(negedge osc);
    cycle(1'b1);
    cycle(1'b1);
    rst_n = 1'b1;
    $display("asynchronous reset: outputs cleared before the next edge");

    // Pad high at release: rise after the full latency.
    lat_a = 0; lat_b = 0;
    for (int k = 1; k <= 30; k++) begin
      cycle(1'b1);
      if (rise_a === 1'b1 && lat_a == 0) lat_a = k;
      if (rise_b === 1'b1 && lat_b == 0) lat_b = k;
    end
    check_eq("release.lat_a", lat_a, SYNC + FL_A);
    check_eq("release.lat_b", lat_b, SYNC + FL_B);
    $display("release with pad high: latency a=%0d b=%0d", lat_a, lat_b);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Safety net in case the clock or the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1, "bench time limit reached");
  end

endmodule
